// File: rtl/trap_controller_pkg.sv
// rtl/trap_controller_pkg.sv - shared CSR addresses, mcause codes and trap FSM states
package trap_controller_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] MCAUSE_LOAD_MISALIGNED  = 32'd4;
    localparam logic [31:0] MCAUSE_STORE_MISALIGNED = 32'd6;
    localparam logic [31:0] MCAUSE_EBREAK           = 32'd3;
    localparam logic [31:0] MCAUSE_ECALL            = 32'd11;
    localparam logic [31:0] MCAUSE_EXT_IRQ          = 32'h8000_000B;

    // Offset into a vectored table for the external interrupt (4 * cause 11).
    localparam logic [31:0] EXT_IRQ_VEC_OFFSET = 32'd44;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MSTATUS,
        RET_MSTATUS,
        REDIRECT
    } trap_state_e;

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r        = ms;
        r[7]     = ms[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Return: MIE <= MPIE, MPIE <= 1, MPP <= U.
    function automatic logic [31:0] ret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r        = ms;
        r[3]     = ms[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b00;
        return r;
    endfunction

endpackage

// File: rtl/trap_priority_enc.sv
// rtl/trap_priority_enc.sv - combinational trap event to mcause priority encoder
module trap_priority_enc
    import trap_controller_pkg::*;
(
    input  logic        misaligned,
    input  logic        misaligned_store,
    input  logic        ebreak,
    input  logic        ecall,
    input  logic        irq_ok,
    output logic        trap_valid,
    output logic        is_irq,
    output logic [31:0] cause
);

    always_comb begin
        trap_valid = 1'b1;
        is_irq     = 1'b0;
        cause      = '0;
        if (misaligned) begin
            cause = misaligned_store ? MCAUSE_STORE_MISALIGNED : MCAUSE_LOAD_MISALIGNED;
        end else if (ebreak) begin
            cause = MCAUSE_EBREAK;
        end else if (ecall) begin
            cause = MCAUSE_ECALL;
        end else if (irq_ok) begin
            cause  = MCAUSE_EXT_IRQ;
            is_irq = 1'b1;
        end else begin
            trap_valid = 1'b0;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - machine-mode trap entry / mret sequencer driving one CSR write port
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int VECTORED_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        mret,
    input  logic        misaligned,
    input  logic        misaligned_store,
    input  logic        ext_irq,
    input  logic [31:0] pc,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic [31:0] mstatus,
    input  logic        mie_meie,
    output logic        stall,
    output logic        flush,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata
);

    trap_state_e state, state_nxt;
    logic [31:0] cause_q, pc_q;
    logic        irq_q, ret_q;

    logic        trap_valid, trap_is_irq;
    logic [31:0] trap_cause;
    logic [31:0] tvec_base;

    trap_priority_enc u_prio (
        .misaligned       (misaligned),
        .misaligned_store (misaligned_store),
        .ebreak           (ebreak),
        .ecall            (ecall),
        .irq_ok           (ext_irq & mstatus[3] & mie_meie),
        .trap_valid       (trap_valid),
        .is_irq           (trap_is_irq),
        .cause            (trap_cause)
    );

    assign tvec_base = {mtvec[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cause_q <= '0;
            pc_q    <= '0;
            irq_q   <= 1'b0;
            ret_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && trap_valid) begin
                cause_q <= trap_cause;
                pc_q    <= pc;
                irq_q   <= trap_is_irq;
                ret_q   <= 1'b0;
            end else if (state == IDLE && mret) begin
                irq_q <= 1'b0;
                ret_q <= 1'b1;
            end
        end
    end

    // Outputs are gated by rst so a sequence in flight goes silent immediately.
    always_comb begin
        state_nxt      = state;
        stall          = 1'b0;
        flush          = 1'b0;
        busy           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        if (!rst) begin
            busy  = (state != IDLE);
            stall = (state != IDLE);
            case (state)
                IDLE: begin
                    if (trap_valid) begin
                        stall     = 1'b1;
                        state_nxt = W_MEPC;
                    end else if (mret) begin
                        stall     = 1'b1;
                        state_nxt = RET_MSTATUS;
                    end
                end
                W_MEPC: begin
                    csr_we    = 1'b1;
                    csr_waddr = CSR_MEPC;
                    csr_wdata = pc_q;
                    state_nxt = W_MCAUSE;
                end
                W_MCAUSE: begin
                    csr_we    = 1'b1;
                    csr_waddr = CSR_MCAUSE;
                    csr_wdata = cause_q;
                    state_nxt = W_MSTATUS;
                end
                W_MSTATUS: begin
                    csr_we    = 1'b1;
                    csr_waddr = CSR_MSTATUS;
                    csr_wdata = trap_mstatus(mstatus);
                    state_nxt = REDIRECT;
                end
                RET_MSTATUS: begin
                    csr_we    = 1'b1;
                    csr_waddr = CSR_MSTATUS;
                    csr_wdata = ret_mstatus(mstatus);
                    state_nxt = REDIRECT;
                end
                REDIRECT: begin
                    flush          = 1'b1;
                    redirect_valid = 1'b1;
                    if (ret_q)
                        redirect_pc = mepc;
                    else if ((VECTORED_EN != 0) && irq_q && (mtvec[1:0] == 2'b01))
                        redirect_pc = tvec_base + EXT_IRQ_VEC_OFFSET;
                    else
                        redirect_pc = tvec_base;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - scoreboard bench for trap_controller
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        ecall, ebreak, mret, misaligned, misaligned_store, ext_irq, mie_meie;
    logic [31:0] pc, mtvec, mepc, mstatus;
    logic        stall, flush, busy, redirect_valid, csr_we;
    logic [31:0] redirect_pc, csr_wdata;
    logic [11:0] csr_waddr;

    trap_controller #(.VECTORED_EN(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .ecall            (ecall),
        .ebreak           (ebreak),
        .mret             (mret),
        .misaligned       (misaligned),
        .misaligned_store (misaligned_store),
        .ext_irq          (ext_irq),
        .pc               (pc),
        .mtvec            (mtvec),
        .mepc             (mepc),
        .mstatus          (mstatus),
        .mie_meie         (mie_meie),
        .stall            (stall),
        .flush            (flush),
        .busy             (busy),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .csr_we           (csr_we),
        .csr_waddr        (csr_waddr),
        .csr_wdata        (csr_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } rd_t;

    wr_t wq[$];
    rd_t rq[$];
    int  ecnt = 0;
    int  vectors = 0;
    int  miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // After each edge: every CSR write / redirect must match the head of its queue.
    task automatic observe();
        wr_t w;
        rd_t r;
        if (csr_we === 1'b1) begin
            if (wq.size() == 0) begin
                check("unexpected_csr_write", {20'd0, csr_waddr}, 32'd0);
            end else begin
                w = wq.pop_front();
                check("csr_write_cycle", ecnt + 1, w.cyc);
                check("csr_waddr", {20'd0, csr_waddr}, {20'd0, w.addr});
                check("csr_wdata", csr_wdata, w.data);
            end
        end else begin
            check("csr_idle_zero", {20'd0, csr_waddr} | csr_wdata, 32'd0);
        end
        if (redirect_valid === 1'b1) begin
            if (rq.size() == 0) begin
                check("unexpected_redirect", redirect_pc, 32'd0);
            end else begin
                r = rq.pop_front();
                check("redirect_cycle", ecnt + 1, r.cyc);
                check("redirect_pc", redirect_pc, r.pc);
            end
        end
        check("flush_eq_redirect", {31'd0, flush}, {31'd0, redirect_valid});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
        observe();
    endtask

    task automatic clear_events();
        ecall = 0; ebreak = 0; mret = 0; misaligned = 0; misaligned_store = 0; ext_irq = 0;
    endtask

    // Called with trap inputs applied, before the acceptance edge t = ecnt + 1.
    task automatic expect_trap(input logic [31:0] p, input logic [31:0] cause,
                               input logic [31:0] ms_wr, input logic [31:0] rpc);
        int t;
        t = ecnt + 1;
        wq.push_back('{t + 1, 12'h341, p});
        wq.push_back('{t + 2, 12'h342, cause});
        wq.push_back('{t + 3, 12'h300, ms_wr});
        rq.push_back('{t + 4, rpc});
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_wq_empty"}, wq.size(), 32'd0);
        check({tag, "_rq_empty"}, rq.size(), 32'd0);
    endtask

    initial begin
        rst = 1; clear_events(); mie_meie = 0;
        pc = 0; mtvec = 0; mepc = 0; mstatus = 0;
        tick(); tick(); tick();
        check("rst_outputs", {27'd0, stall, flush, busy, redirect_valid, csr_we}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        rst = 0;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // ecall at 0x100
        ecall = 1; pc = 32'h100; mtvec = 32'h200; mstatus = 32'h8;
        #1 check("ecall_stall", {31'd0, stall}, 32'd1);
        expect_trap(32'h100, 32'd11, 32'h1880, 32'h200);
        tick(); clear_events();
        check("ecall_busy", {31'd0, busy}, 32'd1);
        drain("ecall");

        // misaligned store wins over ecall
        misaligned = 1; misaligned_store = 1; ecall = 1; pc = 32'h300; mstatus = 32'h0;
        expect_trap(32'h300, 32'd6, 32'h1800, 32'h200);
        tick(); clear_events();
        drain("mis_store");

        // misaligned load wins over ebreak
        misaligned = 1; ebreak = 1; pc = 32'h310; mstatus = 32'h0000_0088;
        expect_trap(32'h310, 32'd4, 32'h0000_1880, 32'h200);
        tick(); clear_events();
        drain("mis_load");

        // ebreak over interrupt, non-vectored redirect
        ebreak = 1; ext_irq = 1; mie_meie = 1; mstatus = 32'h8; pc = 32'h320;
        expect_trap(32'h320, 32'd3, 32'h1880, 32'h200);
        tick(); clear_events();
        drain("ebreak");

        // vectored external interrupt
        ext_irq = 1; mie_meie = 1; mstatus = 32'h8; mtvec = 32'h201; pc = 32'h400;
        expect_trap(32'h400, 32'h8000_000B, 32'h1880, 32'h22C);
        tick(); clear_events();
        drain("irq");

        // mret
        mret = 1; mepc = 32'h104; mstatus = 32'h1880;
        #1 check("mret_stall", {31'd0, stall}, 32'd1);
        wq.push_back('{ecnt + 2, 12'h300, 32'h88});
        rq.push_back('{ecnt + 3, 32'h104});
        tick(); clear_events();
        drain("mret");

        // interrupt masked by mstatus.MIE
        ext_irq = 1; mie_meie = 1; mstatus = 32'h0; mtvec = 32'h200;
        #1 check("masked_stall", {31'd0, stall}, 32'd0);
        tick();
        check("masked_busy", {31'd0, busy}, 32'd0);
        tick();
        check("masked_busy2", {31'd0, busy}, 32'd0);
        clear_events();

        // reset during W_MCAUSE aborts the sequence
        ecall = 1; pc = 32'h500; mstatus = 32'h8;
        wq.push_back('{ecnt + 2, 12'h341, 32'h500});
        wq.push_back('{ecnt + 3, 12'h342, 32'd11});
        tick(); clear_events();
        tick();
        rst = 1;
        #1 check("rst_mid_comb", {27'd0, stall, flush, busy, redirect_valid, csr_we}, 32'd0);
        tick();
        check("rst_mid_outputs", {27'd0, stall, flush, busy, redirect_valid, csr_we}, 32'd0);
        rst = 0;
        for (int i = 0; i < 6; i++) tick();
        check("rst_abort_busy", {31'd0, busy}, 32'd0);
        check("rst_abort_wq", wq.size(), 32'd0);
        check("rst_abort_rq", rq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameter VECTORED_EN, default 1: 1 allows vectored mtvec mode for interrupts; 0 always uses the base address.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have ports ecall, ebreak, mret, input, 1 bit each: decoded instruction events from the execute stage.
REQ-005 SHALL have ports misaligned and misaligned_store, input, 1 bit each: misaligned access; _store=1 means store, 0 means load.
REQ-006 SHALL have port ext_irq, input, 1 bit: level-sensitive external interrupt.
REQ-007 SHALL have ports pc, mtvec, mepc and mstatus, input, 32 bits each: current PC and current CSR values.
REQ-008 SHALL have port mie_meie, input, 1 bit: mie.MEIE.
REQ-009 SHALL have ports stall, flush and busy, output, 1 bit each: pipeline hold, pipeline kill and FSM-not-idle.
REQ-010 SHALL have port redirect_valid, output, 1 bit, and port redirect_pc, output, 32 bits: one-cycle PC redirect.
REQ-011 SHALL have ports csr_we (output, 1), csr_waddr (output, 12) and csr_wdata (output, 32): single CSR write port, one write per cycle.

Function
REQ-012 SHALL use FSM states IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, RET_MSTATUS and REDIRECT.
REQ-013 SHALL sample events only in IDLE; events in any other state SHALL be ignored, because producers are held by stall.
REQ-014 SHALL resolve simultaneous trap events by priority: misaligned > ebreak > ecall > interrupt.
REQ-015 SHALL take an interrupt only when ext_irq=1, mstatus[3]=1 and mie_meie=1.
REQ-016 SHALL give any trap priority over a simultaneous mret; the mret is then dropped.
REQ-017 SHALL latch cause and pc on trap acceptance, using mcause values:
- load misaligned: 4
- store misaligned: 6
- ebreak: 3
- ecall: 11
- external interrupt: 0x8000000B
REQ-018 SHALL, on a trap accepted at edge t, sequence as follows:
- W_MEPC in cycle t+1: write 0x341 with the latched pc
- W_MCAUSE in t+2: write 0x342 with the latched cause
- W_MSTATUS in t+3: write 0x300
- REDIRECT in t+4
- IDLE in t+5
REQ-019 SHALL form the trap mstatus write from the input mstatus as: bit7 <= mstatus[3]; bit3 <= 0; bits[12:11] <= 2'b11; all other bits unchanged.
REQ-020 SHALL, on mret accepted at edge t, enter RET_MSTATUS in t+1, then REDIRECT in t+2, then IDLE in t+3.
REQ-021 SHALL form the RET_MSTATUS write to 0x300 from the input mstatus as: bit3 <= mstatus[7]; bit7 <= 1; bits[12:11] <= 2'b00; all other bits unchanged.
REQ-022 SHALL drive csr_we=1 only in W_MEPC, W_MCAUSE, W_MSTATUS and RET_MSTATUS; csr_waddr and csr_wdata SHALL be 0 whenever csr_we=0.
REQ-023 SHALL, in REDIRECT, assert redirect_valid=1 and flush=1 for exactly one cycle.
REQ-024 SHALL set redirect_pc as follows:
- mret: mepc
- interrupt with VECTORED_EN=1 and mtvec[1:0]=01: {mtvec[31:2],2'b00} + 44
- otherwise: {mtvec[31:2],2'b00}
REQ-025 SHALL assert stall combinationally in IDLE when any accepted event is present, and in every non-IDLE state.
REQ-026 SHALL drive busy=1 in every state other than IDLE.
REQ-027 SHALL compute redirect_pc arithmetic modulo 2^32 with no overflow flag.

Reset
REQ-028 SHALL, on rst, enter IDLE at the next edge and clear all latched cause/pc registers.
REQ-029 SHALL drive all outputs to 0 while in reset.
REQ-030 SHALL, when reset is asserted mid-sequence, abort the sequence: no further CSR write, and no redirect, is issued after the reset edge.

Structure
REQ-031 SHALL place the following in the shared common package:
- CSR addresses 0x300, 0x341, 0x342
- mcause constants
- the FSM state encoding
REQ-032 SHALL contain one optional sub-module, trap_priority_enc (combinational event-to-cause encoder); no other hierarchy.

Verification
REQ-033 Bench SHALL cover these scenarios:
- ecall at pc=0x100, mtvec=0x200, mstatus=0x8: writes 0x341=0x100, 0x342=11, 0x300=0x1880; redirect_pc=0x200 at t+4.
- misaligned store and ecall in the same cycle: mcause=6; the ecall is dropped.
- ext_irq=1, mstatus[3]=1, mie_meie=1, mtvec=0x201: redirect_pc=0x22C; mcause=0x8000000B.
- mret with mepc=0x104, mstatus=0x1880: 0x300 write=0x88 at t+1; redirect_pc=0x104 at t+2; flush 1 cycle.
- ext_irq=1 with mstatus[3]=0: no trap, stall=0, busy=0.
- rst asserted in W_MCAUSE: no 0x300 write, no redirect; IDLE with all outputs 0 after the edge.
